// File: rtl/semiauto_turn_sequencer.sv
// Registered state/command stage behind the semi-auto decision logic.
// Times the TURN and COOL phases and drives the motor command and lights.
module semiauto_turn_sequencer #(
    parameter int TICK_DIV = 100000,
    parameter int TURN_MS  = 900,
    parameter int BACK_MS  = 1800,
    parameter int COOL_MS  = 500
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    input  logic       back_req,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       move_forward_light,
    output logic       move_backward_light,
    output logic       turn_left_light,
    output logic       turn_right_light,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_FWD  = 2'b00,
        S_WAIT = 2'b01,
        S_TURN = 2'b10,
        S_COOL = 2'b11
    } state_t;

    localparam logic [3:0] STOP  = 4'b0000;
    localparam logic [3:0] FWD   = 4'b0001;
    localparam logic [3:0] LEFT  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b1000;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [10:0]   TURN_LD  = 11'(TURN_MS);
    localparam logic [10:0]   BACK_LD  = 11'(BACK_MS);
    localparam logic [10:0]   COOL_LD  = 11'(COOL_MS);

    state_t        st_q, st_d;
    logic [3:0]    mv_q, mv_d;
    logic [3:0]    dir_q, dir_d;
    logic          u_q, u_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;

    logic tick;
    logic req_turn, req_fwd, req_wait, req_u;

    assign tick     = (pre_q == PRE_LAST);
    assign req_turn = (next_state == S_TURN) &&
                      (next_moving_state == LEFT ||
                       next_moving_state == RIGHT);
    assign req_fwd  = (next_state == S_FWD) && (next_moving_state == FWD);
    assign req_wait = (next_state == S_WAIT) && (next_moving_state == STOP);
    assign req_u    = back_req && (next_moving_state == RIGHT);

    always_comb begin
        st_d  = st_q;
        mv_d  = mv_q;
        dir_d = dir_q;
        u_d   = u_q;
        cnt_d = cnt_q;
        pre_d = pre_q;
        case (st_q)
            S_TURN: begin
                mv_d  = dir_q;
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (cnt_q == 11'd1) begin
                        st_d  = S_COOL;
                        mv_d  = FWD;
                        cnt_d = COOL_LD;
                        pre_d = '0;
                    end else if (cnt_q != 11'd0) begin
                        cnt_d = cnt_q - 11'd1;
                    end
                end
            end
            S_COOL: begin
                mv_d  = FWD;
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (cnt_q == 11'd1) begin
                        st_d  = S_FWD;
                        cnt_d = '0;
                        pre_d = '0;
                        u_d   = 1'b0;
                    end else if (cnt_q != 11'd0) begin
                        cnt_d = cnt_q - 11'd1;
                    end
                end
            end
            default: begin
                cnt_d = '0;
                pre_d = '0;
                unique case (1'b1)
                    req_turn: begin
                        st_d  = S_TURN;
                        mv_d  = next_moving_state;
                        dir_d = next_moving_state;
                        u_d   = req_u;
                        cnt_d = req_u ? BACK_LD : TURN_LD;
                    end
                    req_fwd: begin
                        st_d = S_FWD;
                        mv_d = FWD;
                    end
                    req_wait: begin
                        st_d = S_WAIT;
                        mv_d = STOP;
                    end
                    default: begin
                        st_d = S_WAIT;
                        mv_d = STOP;
                    end
                endcase
            end
        endcase
        // Dropping enable aborts everything, including an active turn.
        if (!enable) begin
            st_d  = S_WAIT;
            mv_d  = STOP;
            dir_d = STOP;
            u_d   = 1'b0;
            cnt_d = '0;
            pre_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            st_q                <= S_WAIT;
            mv_q                <= STOP;
            dir_q               <= STOP;
            u_q                 <= 1'b0;
            cnt_q               <= '0;
            pre_q               <= '0;
            move_forward_light  <= 1'b0;
            move_backward_light <= 1'b0;
            turn_left_light     <= 1'b0;
            turn_right_light    <= 1'b0;
            busy                <= 1'b0;
        end else begin
            st_q                <= st_d;
            mv_q                <= mv_d;
            dir_q               <= dir_d;
            u_q                 <= u_d;
            cnt_q               <= cnt_d;
            pre_q               <= pre_d;
            move_forward_light  <= (mv_d == FWD);
            move_backward_light <= (st_d == S_TURN) && u_d;
            turn_left_light     <= (mv_d == LEFT);
            turn_right_light    <= (mv_d == RIGHT);
            busy                <= (st_d == S_TURN) || (st_d == S_COOL);
        end
    end

    assign state        = st_q;
    assign moving_state = mv_q;

endmodule

// File: tb/tb_semiauto_turn_sequencer.sv
// Scoreboard bench for semiauto_turn_sequencer with short timers.
// Driver queues hand-derived expectations; monitor pops one per edge.
module tb_semiauto_turn_sequencer;

    localparam logic [1:0] S1 = 2'b00;
    localparam logic [1:0] S2 = 2'b01;
    localparam logic [1:0] S3 = 2'b10;
    localparam logic [1:0] S4 = 2'b11;
    localparam logic [3:0] STOP = 4'b0000;
    localparam logic [3:0] FWD  = 4'b0001;
    localparam logic [3:0] TL   = 4'b0100;
    localparam logic [3:0] TR   = 4'b1000;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       back_req;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       move_forward_light;
    logic       move_backward_light;
    logic       turn_left_light;
    logic       turn_right_light;
    logic       busy;

    semiauto_turn_sequencer #(
        .TICK_DIV(4),
        .TURN_MS (3),
        .BACK_MS (6),
        .COOL_MS (2)
    ) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .enable             (enable),
        .next_state         (next_state),
        .next_moving_state  (next_moving_state),
        .back_req           (back_req),
        .state              (state),
        .moving_state       (moving_state),
        .move_forward_light (move_forward_light),
        .move_backward_light(move_backward_light),
        .turn_left_light    (turn_left_light),
        .turn_right_light   (turn_right_light),
        .busy               (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [3:0] mv;
        logic [3:0] lt;
        logic       busy;
    } exp_t;

    exp_t  q[$];
    string phase = "init";
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic exp_t mk(input logic [1:0] st, input logic [3:0] mv,
                                input logic back, input logic bz);
        exp_t e;
        e.tag  = phase;
        e.st   = st;
        e.mv   = mv;
        e.lt   = {mv == FWD, back, mv == TL, mv == TR};
        e.busy = bz;
        return e;
    endfunction

    task automatic cyc(input logic en, input logic [1:0] ns,
                       input logic [3:0] nm, input logic br,
                       input logic [1:0] est, input logic [3:0] emv,
                       input logic eback, input logic ebusy);
        @(negedge sys_clk);
        enable            = en;
        next_state        = ns;
        next_moving_state = nm;
        back_req          = br;
        q.push_back(mk(est, emv, eback, ebusy));
    endtask

    task automatic areset();
        @(negedge sys_clk);
        #2;
        q.push_back(mk(S2, STOP, 1'b0, 1'b0));
        rst = 1'b0;
    endtask

    task automatic rel();
        @(negedge sys_clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] lt;
        forever begin
            @(posedge sys_clk or negedge rst);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                lt = {move_forward_light, move_backward_light,
                      turn_left_light, turn_right_light};
                n_tests++;
                if (state !== e.st || moving_state !== e.mv ||
                    lt !== e.lt || busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s: got st=%b mv=%b lt=%b busy=%b, want st=%b mv=%b lt=%b busy=%b",
                             e.tag, state, moving_state, lt, busy,
                             e.st, e.mv, e.lt, e.busy);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b0;
        enable = 1'b0;
        next_state = S2;
        next_moving_state = STOP;
        back_req = 1'b0;

        phase = "reset_hold";
        cyc(0, S1, FWD, 0, S2, STOP, 0, 0);
        cyc(1, S1, FWD, 0, S2, STOP, 0, 0);
        rel();

        phase = "pass_fwd";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        phase = "pass_wait";
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        phase = "async_reset";
        areset();
        rel();
        phase = "pass_after_rst";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        phase = "enable_low";
        cyc(0, S1, FWD, 0, S2, STOP, 0, 0);
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);

        phase = "left_enter";
        cyc(1, S3, TL, 0, S3, TL, 0, 1);
        phase = "left_s3_ignore_in";
        for (int i = 0; i < 11; i++) cyc(1, S1, FWD, 0, S3, TL, 0, 1);
        phase = "left_s4";
        for (int i = 0; i < 8; i++) cyc(1, S2, STOP, 0, S4, FWD, 0, 1);
        phase = "left_done";
        cyc(1, S2, STOP, 0, S1, FWD, 0, 0);
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);

        phase = "uturn_enter";
        cyc(1, S3, TR, 1, S3, TR, 1, 1);
        phase = "uturn_s3";
        for (int i = 0; i < 23; i++)
            cyc(1, S2, STOP, (i % 4) >= 2, S3, TR, 1, 1);
        phase = "uturn_s4";
        for (int i = 0; i < 8; i++) cyc(1, S3, TL, 1, S4, FWD, 0, 1);
        phase = "uturn_done";
        cyc(1, S2, STOP, 0, S1, FWD, 0, 0);
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);

        phase = "right_enter";
        cyc(1, S3, TR, 0, S3, TR, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, S2, STOP, 0, S3, TR, 0, 1);
        phase = "abort_enable";
        cyc(0, S2, STOP, 0, S2, STOP, 0, 0);
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);

        phase = "left2_s3";
        cyc(1, S3, TL, 0, S3, TL, 0, 1);
        for (int i = 0; i < 11; i++) cyc(1, S2, STOP, 0, S3, TL, 0, 1);
        phase = "left2_s4";
        for (int i = 0; i < 3; i++) cyc(1, S2, STOP, 0, S4, FWD, 0, 1);
        phase = "abort_rst_s4";
        areset();
        rel();
        phase = "after_abort";
        cyc(1, S2, STOP, 0, S2, STOP, 0, 0);

        phase = "illegal_s3_fwd";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        cyc(1, S3, FWD, 0, S2, STOP, 0, 0);
        phase = "illegal_s4_req";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        cyc(1, S4, TR, 0, S2, STOP, 0, 0);
        phase = "illegal_cmd";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        cyc(1, S1, 4'b0110, 0, S2, STOP, 0, 0);
        phase = "illegal_s3_stop";
        cyc(1, S1, FWD, 0, S1, FWD, 0, 0);
        cyc(1, S3, STOP, 0, S2, STOP, 0, 0);

        repeat (3) @(posedge sys_clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/semiauto_turn_sequencer.md
Name: semiauto_turn_sequencer

Overview:
- Registered stage directly downstream of the semi-auto decision logic.
- Consumes its combinational next_state / next_moving_state proposal and drives the registered state back to it.
- Owns the TURN (s3) and COOLDOWN (s4) phases with millisecond timers, and drives the motor command and indicator lights.
- Produces the moving_state command consumed by the motor driver.

Parameters:
- TICK_DIV, 100000: sys_clk cycles per 1 ms tick.
- TURN_MS, 900: duration of a 90-degree turn in ticks; legal range 1..2047.
- BACK_MS, 1800: duration of a U-turn (go_back) in ticks; legal range 1..2047.
- COOL_MS, 500: forward-only cooldown after any turn, in ticks; legal range 1..2047.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  power on and global_state is semi-auto (01) or auto (10).
- next_state  in  2  proposed state: s1=00 FORWARD, s2=01 WAIT, s3=10 TURN, s4=11 COOL.
- next_moving_state  in  4  proposed command: STOP=0000, MOVE_FORWARD=0001, TURN_LEFT=0100, TURN_RIGHT=1000.
- back_req  in  1  high means the requested TURN_RIGHT is a U-turn.
- state  out  2  registered current state, fed back upstream.
- moving_state  out  4  registered motor command.
- move_forward_light  out  1  high when moving_state==MOVE_FORWARD.
- move_backward_light  out  1  high during a U-turn in s3.
- turn_left_light  out  1  high when moving_state==TURN_LEFT.
- turn_right_light  out  1  high when moving_state==TURN_RIGHT.
- busy  out  1  high in s3 or s4, when upstream proposals are ignored.

Behaviour:
- Clock and reset
  - Single clock domain.
  - rst low (asynchronous): state=s2, moving_state=STOP, all lights=0, busy=0, tick counter=0, prescaler=0, latched direction=STOP, u-turn flag=0.
- Enable
  - enable low at a clock edge: same values as reset, applied synchronously.
  - enable has priority over all transitions.
- Output timing: all outputs are registered; one-cycle latency from inputs.
- s1/s2 (pass-through)
  - State and command copy next_state / next_moving_state each edge.
  - Legal pairs: (s1, MOVE_FORWARD), (s2, STOP), (s3, TURN_LEFT or TURN_RIGHT).
  - Any other pair (illegal code, s4 request, or s3 with a non-turn command): state=s2, moving_state=STOP.
- Entering s3
  - Latch the direction.
  - Latch u_turn = back_req & (direction==TURN_RIGHT).
  - Load the counter with BACK_MS if u_turn, else TURN_MS.
  - Clear the prescaler.
- Prescaler
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler==TICK_DIV-1).
- s3
  - Upstream inputs are ignored.
  - moving_state holds the latched direction.
  - The counter decrements on each tick.
  - On a tick with counter==1: go to s4, moving_state=MOVE_FORWARD, load COOL_MS, clear the prescaler.
  - s3 therefore lasts exactly load×TICK_DIV cycles.
- s4
  - Inputs are ignored and moving_state=MOVE_FORWARD.
  - On a tick with counter==1: go to s1, moving_state=MOVE_FORWARD; u_turn clears.
  - s4 lasts exactly COOL_MS×TICK_DIV cycles.
- Lights
  - Decoded from the registered next values, so they change on the same edge as moving_state.
  - move_backward_light = (state==s3) & u_turn.
- Widths
  - Counter is 11 bits; prescaler is ceil(log2(TICK_DIV)) bits, minimum 1.
  - Counter never underflows; it stops at 0 outside s3/s4.
- Mid-operation events
  - Reset or enable drop in s3/s4 aborts the turn immediately.
  - back_req changes in s3 have no effect.

Test Plan:
- Reset and pass-through: rst low mid-run → state=01, moving_state=0000 with no clock edge. Release, then enable=1, next_state=00, next_moving_state=0001 → after 1 edge state=00, moving_state=0001, move_forward_light=1.
- Left turn timing (TICK_DIV=4, TURN_MS=3, COOL_MS=2): in s2 apply (10, 0100) → next edge state=10, moving_state=0100, turn_left_light=1. Then state=11, moving 0001 for exactly 8 cycles after 12 cycles; then state=00, busy=0.
- U-turn (BACK_MS=6): (10, 1000) with back_req=1 → 24 cycles in s3 with turn_right_light=1 and move_backward_light=1, then 8 cycles in s4. Toggling back_req mid-turn changes nothing.
- Input ignored while busy: during s3, drive (00, 0001) → state stays 10 until the timer expires.
- Abort: enable=0 at the 5th cycle of s3 → next edge state=01, moving_state=0000, busy=0. rst pulsed low mid-s4 → immediate 01/0000.
- Illegal codes: (10, 0001), (11, 1000), (00, 0110) from s2 → each yields state=01, moving_state=0000.
